// File: rtl/pulpino_unpack_pkg.sv
// Shared types and helpers for the AXI4-Stream instruction unpacker.
// Used by axis_instr_unpacker and axis_unpack_buf.
package pulpino_unpack_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} unpack_state_t;

  localparam int unsigned LP_WORD_WIDTH = 32;

  function automatic logic [LP_WORD_WIDTH-1:0] byte_swap32(
    input logic [LP_WORD_WIDTH-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/axis_unpack_buf.sv
// Holding register for one wide input beat, the slot counter and the output word mux.
// The slot counter walks the beat from the LSB word upwards.
module axis_unpack_buf
  import pulpino_unpack_pkg::*;
#(
  parameter int unsigned InWidth  = 512,
  parameter int unsigned OutWidth = LP_WORD_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [InWidth-1:0]  load_data_i,
  input  logic                load_last_i,
  input  logic                advance_i,
  input  logic                clear_i,
  output logic                valid_o,
  output logic                slot_end_o,
  output logic                last_o,
  output logic [OutWidth-1:0] word_o
);

  localparam int unsigned Ratio = InWidth / OutWidth;
  localparam int unsigned SlotW = (Ratio > 1) ? $clog2(Ratio) : 1;

  logic [InWidth-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [SlotW-1:0]   slot_q, slot_d;

  assign slot_end_o = (slot_q == SlotW'(Ratio - 1));
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign word_o     = data_q[slot_q * OutWidth +: OutWidth];

  // A load in the same cycle as the final-slot advance takes priority, giving
  // back-to-back beats without a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    slot_d  = slot_q;
    if (clear_i) begin
      valid_d = 1'b0;
      slot_d  = '0;
    end else if (load_i) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
      last_d  = load_last_i;
      slot_d  = '0;
    end else if (advance_i) begin
      if (slot_end_o) begin
        valid_d = 1'b0;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      slot_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: rtl/axis_instr_unpacker.sv
// Downsizes a wide AXI4-Stream into ctrl_instr_num instruction words, then flushes to tlast.
// Define UNPACKER_BYTE_SWAP_EN to byte-reverse every output word.
module axis_instr_unpacker
  import pulpino_unpack_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_COUNT_WIDTH        = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  input  logic [C_COUNT_WIDTH-1:0]        ctrl_instr_num,
  output logic                            ctrl_done,
  output logic                            ctrl_underrun,
  output logic [C_COUNT_WIDTH-1:0]        word_count,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast
);

  localparam logic [C_COUNT_WIDTH-1:0] CountOne = 1;
  localparam logic [C_COUNT_WIDTH-1:0] CountMax = '1;

  unpack_state_t state_q, state_d;

  logic [C_COUNT_WIDTH-1:0] n_q, n_d;
  logic [C_COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                     underrun_q, underrun_d;

  logic                            buf_valid;
  logic                            buf_slot_end;
  logic                            buf_last;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] buf_word;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] out_word;

  logic count_end;
  logic word_last;
  logic in_hs;
  logic out_hs;

  assign count_end = (word_count_q == (n_q - CountOne));
  assign word_last = buf_valid && (count_end || (buf_last && buf_slot_end));
  assign in_hs     = s_axis_tvalid && s_axis_tready;
  assign out_hs    = m_axis_tvalid && m_axis_tready;

`ifdef UNPACKER_BYTE_SWAP_EN
  assign out_word = byte_swap32(buf_word);
`else
  assign out_word = buf_word;
`endif

  axis_unpack_buf #(
    .InWidth  (C_S_AXIS_TDATA_WIDTH),
    .OutWidth (C_M_AXIS_TDATA_WIDTH)
  ) u_buf (
    .clk_i       (aclk),
    .rst_i       (areset),
    .load_i      ((state_q == RUN) && in_hs),
    .load_data_i (s_axis_tdata),
    .load_last_i (s_axis_tlast),
    .advance_i   (out_hs),
    .clear_i     (out_hs && word_last),
    .valid_o     (buf_valid),
    .slot_end_o  (buf_slot_end),
    .last_o      (buf_last),
    .word_o      (buf_word)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          state_d = (ctrl_instr_num == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (out_hs && word_last) begin
          if (count_end) begin
            state_d = buf_last ? DONE : FLUSH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FLUSH: begin
        if (in_hs && s_axis_tlast) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final word never pulls in a new beat; anything left over is drained by FLUSH,
  // so a tlast beat is never swallowed while leaving RUN.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    ctrl_done     = 1'b0;
    unique case (state_q)
      RUN: begin
        m_axis_tvalid = buf_valid;
        m_axis_tlast  = word_last;
        m_axis_tdata  = buf_valid ? out_word : '0;
        s_axis_tready = !buf_valid || (buf_slot_end && m_axis_tready && !word_last);
      end
      FLUSH:   s_axis_tready = 1'b1;
      DONE:    ctrl_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    n_d          = n_q;
    word_count_d = word_count_q;
    underrun_d   = underrun_q;
    if ((state_q == IDLE) && ctrl_start) begin
      n_d          = ctrl_instr_num;
      word_count_d = '0;
      underrun_d   = 1'b0;
    end else if ((state_q == RUN) && out_hs) begin
      word_count_d = (word_count_q == CountMax) ? word_count_q : word_count_q + CountOne;
      if (word_last && !count_end) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      n_q          <= '0;
      word_count_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      n_q          <= n_d;
      word_count_q <= word_count_d;
      underrun_q   <= underrun_d;
    end
  end

  assign word_count    = word_count_q;
  assign ctrl_underrun = underrun_q;

endmodule

// File: tb/tb_axis_instr_unpacker.sv
// Self-checking bench for axis_instr_unpacker: table of transfers plus a mid-run reset sequence.
// Output words are checked against a scoreboard queue filled when each transfer is armed.
module tb_axis_instr_unpacker;

  localparam int SW = 512;
  localparam int MW = 32;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ctrl_start;
  logic [CW-1:0] ctrl_instr_num;
  logic          ctrl_done;
  logic          ctrl_underrun;
  logic [CW-1:0] word_count;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [SW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [MW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  always #5 aclk = ~aclk;

  axis_instr_unpacker #(
    .C_S_AXIS_TDATA_WIDTH (SW),
    .C_M_AXIS_TDATA_WIDTH (MW),
    .C_COUNT_WIDTH        (CW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .ctrl_start     (ctrl_start),
    .ctrl_instr_num (ctrl_instr_num),
    .ctrl_done      (ctrl_done),
    .ctrl_underrun  (ctrl_underrun),
    .word_count     (word_count),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast)
  );

  typedef struct {
    int unsigned n;
    int          beats;
    bit          rnd_ready;
    int          exp_words;
    bit          exp_underrun;
  } vec_t;

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
  } word_t;

  vec_t  vecs[7];
  word_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] exp_word(input int i);
    logic [31:0] w;
    w = i;
`ifdef UNPACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Word k of beat b carries the global index b*16+k.
  function automatic logic [SW-1:0] make_beat(input int b);
    logic [SW-1:0] d;
    for (int k = 0; k < SW / MW; k++) begin
      d[k*MW +: MW] = MW'(b * (SW / MW) + k);
    end
    return d;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_ctrl_done"}, ctrl_done, 0);
    check({tag, "_underrun"}, ctrl_underrun, 0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int            beat;
    int            cyc;
    int            idx;
    bit            done_seen;
    bit            end_prev;
    bit            end_now;
    bit            stall_prev;
    logic [MW-1:0] pd;
    logic          pl;
    word_t         w;
    beat = 0; cyc = 0; idx = 0;
    done_seen = 0; end_prev = 0; stall_prev = 0;
    pd = '0; pl = 1'b0;
    sb.delete();
    for (int i = 0; i < v.exp_words; i++) begin
      w.data = exp_word(i);
      w.last = (i == v.exp_words - 1);
      sb.push_back(w);
    end
    @(negedge aclk);
    ctrl_instr_num = v.n;
    ctrl_start     = 1'b1;
    @(negedge aclk);
    ctrl_start = 1'b0;
    while (!done_seen && cyc < 2000) begin
      m_axis_tready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beat < v.beats) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = make_beat(beat);
        s_axis_tlast  = (beat == v.beats - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      #1;
      if (ctrl_done) begin
        done_seen = 1;
        check({tag, "_done_latency"}, end_prev, 1);
      end else begin
        if (stall_prev) begin
          check({tag, "_stall_valid"}, m_axis_tvalid, 1);
          check({tag, "_stall_data"}, m_axis_tdata, pd);
          check({tag, "_stall_last"}, m_axis_tlast, pl);
        end
        end_now = 0;
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_extra_word: got 0x%0h, expected no word", tag, m_axis_tdata);
          end else begin
            w = sb.pop_front();
            check({tag, "_data"}, m_axis_tdata, w.data);
            check({tag, "_last"}, m_axis_tlast, w.last);
          end
          if ((idx % 16) == 15 && idx != v.exp_words - 1) begin
            check({tag, "_b2b_beat"}, s_axis_tvalid && s_axis_tready, 1);
          end
          end_now = m_axis_tlast;
          idx++;
        end
        if (s_axis_tvalid && s_axis_tready) begin
          if (s_axis_tlast && !m_axis_tvalid) end_now = 1;
          beat++;
        end
        end_prev   = end_now;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        pd         = m_axis_tdata;
        pl         = m_axis_tlast;
      end
      cyc++;
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_done_one_cycle"}, ctrl_done, 0);
    check({tag, "_words_left"}, sb.size(), 0);
    check({tag, "_beats_taken"}, beat, v.beats);
    check({tag, "_underrun"}, ctrl_underrun, v.exp_underrun);
    check({tag, "_word_count"}, word_count, v.exp_words);
  endtask

  initial begin
    int words;
    int cyc;
    bit hs_in;
    vecs[0] = '{n: 16, beats: 1, rnd_ready: 0, exp_words: 16, exp_underrun: 0};
    vecs[1] = '{n: 20, beats: 2, rnd_ready: 0, exp_words: 20, exp_underrun: 0};
    vecs[2] = '{n: 40, beats: 2, rnd_ready: 0, exp_words: 32, exp_underrun: 1};
    vecs[3] = '{n: 0,  beats: 3, rnd_ready: 0, exp_words: 0,  exp_underrun: 0};
    vecs[4] = '{n: 48, beats: 3, rnd_ready: 1, exp_words: 48, exp_underrun: 0};
    vecs[5] = '{n: 16, beats: 2, rnd_ready: 1, exp_words: 16, exp_underrun: 0};
    vecs[6] = '{n: 1,  beats: 1, rnd_ready: 0, exp_words: 1,  exp_underrun: 0};

    areset         = 1'b1;
    ctrl_start     = 1'b0;
    ctrl_instr_num = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN after five words have left.
    @(negedge aclk);
    ctrl_instr_num = 16;
    ctrl_start     = 1'b1;
    @(negedge aclk);
    ctrl_start    = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = make_beat(0);
    s_axis_tlast  = 1'b1;
    words = 0;
    cyc   = 0;
    hs_in = 0;
    while (words < 5 && cyc < 100) begin
      #1;
      if (s_axis_tvalid && s_axis_tready) hs_in = 1;
      if (m_axis_tvalid && m_axis_tready) words++;
      @(negedge aclk);
      if (hs_in) s_axis_tvalid = 1'b0;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    check("midrun_word_count", word_count, 5);
    check("midrun_valid", m_axis_tvalid, 1);
    #1;
    areset = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("midrun_no_done", ctrl_done, 0);
    end
    areset = 1'b0;
    #1;
    check_idle_outputs("midrun_release");
    run_case('{n: 4, beats: 1, rnd_ready: 0, exp_words: 4, exp_underrun: 0}, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
